// File: rtl/regfile_mp.sv
// Multi-port register file with write-port priority, optional write-to-read
// bypass, a per-register busy scoreboard and a hardware clear sweep.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NRD*ADDR_W-1:0]   Rd_addr,
  output logic [NRD*DATA_W-1:0]   Rd_data,
  output logic [NRD-1:0]          Rd_busy,
  input  logic [NWR-1:0]          Wr_en,
  input  logic [NWR*ADDR_W-1:0]   Wr_addr,
  input  logic [NWR*DATA_W-1:0]   Wr_data,
  input  logic [NWR-1:0]          Rsv_en,
  input  logic [NWR*ADDR_W-1:0]   Rsv_addr,
  input  logic                    Clear_req,
  output logic                    Clear_busy
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0]   rf [NREG];
  logic [NREG-1:0]     busy;

  logic [NREG-1:0]     wr_hit;
  logic [NREG-1:0]     rsv_hit;
  logic [DATA_W-1:0]   wr_val [NREG];
  logic [ADDR_W-1:0]   wa, rsva, ra;

  // Per-register view of this cycle's writes and reserves; ascending port
  // order lets the highest-index write port win a collision.
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    wa      = '0;
    rsva    = '0;
    for (int r = 0; r < NREG; r++) wr_val[r] = '0;
    if (state == IDLE) begin
      for (int j = 0; j < NWR; j++) begin
        wa = Wr_addr[j*ADDR_W +: ADDR_W];
        if (Wr_en[j] && wa != '0) begin
          wr_hit[wa] = 1'b1;
          wr_val[wa] = Wr_data[j*DATA_W +: DATA_W];
        end
        rsva = Rsv_addr[j*ADDR_W +: ADDR_W];
        if (Rsv_en[j] && rsva != '0) rsv_hit[rsva] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
      busy <= '0;
    end else if (state == SWEEP) begin
      rf[idx]   <= '0;
      busy[idx] <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)
        if (wr_hit[r]) rf[r] <= wr_val[r];
      // Reserve is applied after the write-clear so it wins on a tie.
      busy <= (busy & ~wr_hit) | rsv_hit;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (Clear_req) begin
          state_nxt = SWEEP;
          idx_nxt   = ADDR_W'(1);
        end
      end
      SWEEP: begin
        idx_nxt = idx + ADDR_W'(1);
        if (idx == ADDR_W'(NREG - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Clear_busy = (state == SWEEP);

  // wr_hit is already gated to IDLE, so bypass vanishes during a sweep.
  always_comb begin
    Rd_data = '0;
    Rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = Rd_addr[i*ADDR_W +: ADDR_W];
      if (ra != '0) begin
        if (BYPASS != 0 && wr_hit[ra])
          Rd_data[i*DATA_W +: DATA_W] = wr_val[ra];
        else
          Rd_data[i*DATA_W +: DATA_W] = rf[ra];
        Rd_busy[i] = (BYPASS != 0 && wr_hit[ra] && !rsv_hit[ra]) ? 1'b0 : busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized plus directed bench for regfile_mp; a BYPASS=1 and a BYPASS=0
// instance share stimulus and are checked against one behavioural model.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
  localparam int NREG   = 32;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data_b1, rd_data_b0;
  logic [NRD-1:0]        rd_busy_b1, rd_busy_b0;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR-1:0]        rsv_en;
  logic [NWR*ADDR_W-1:0] rsv_addr;
  logic                  clear_req;
  logic                  clear_busy_b1, clear_busy_b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_rf [NREG];
  logic              m_busy [NREG];
  bit                m_sweep;
  int                m_cnt;
  bit                m_valid = 0;

  always #5 Clk = ~Clk;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b1 (
    .Clk(Clk), .Reset_n(Reset_n), .Rd_addr(rd_addr), .Rd_data(rd_data_b1),
    .Rd_busy(rd_busy_b1), .Wr_en(wr_en), .Wr_addr(wr_addr), .Wr_data(wr_data),
    .Rsv_en(rsv_en), .Rsv_addr(rsv_addr), .Clear_req(clear_req), .Clear_busy(clear_busy_b1));

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b0 (
    .Clk(Clk), .Reset_n(Reset_n), .Rd_addr(rd_addr), .Rd_data(rd_data_b0),
    .Rd_busy(rd_busy_b0), .Wr_en(wr_en), .Wr_addr(wr_addr), .Wr_data(wr_data),
    .Rsv_en(rsv_en), .Rsv_addr(rsv_addr), .Clear_req(clear_req), .Clear_busy(clear_busy_b0));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_wrote(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    bit hit = 0;
    d = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) begin
        hit = 1;
        d = wr_data[j*DATA_W +: DATA_W];
      end
    return hit;
  endfunction

  function automatic bit m_reserved(input logic [ADDR_W-1:0] a);
    for (int j = 0; j < NWR; j++)
      if (rsv_en[j] && rsv_addr[j*ADDR_W +: ADDR_W] == a) return 1;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a, input bit byp);
    logic [DATA_W-1:0] d;
    if (a == 0) return '0;
    if (byp && !m_sweep && m_wrote(a, d)) return d;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a, input bit byp);
    logic [DATA_W-1:0] d;
    if (a == 0) return 1'b0;
    if (byp && !m_sweep && m_wrote(a, d) && !m_reserved(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    logic [ADDR_W-1:0] a;
    chk("clear_busy_b1", 64'(clear_busy_b1), 64'(m_sweep));
    chk("clear_busy_b0", 64'(clear_busy_b0), 64'(m_sweep));
    if (Reset_n) begin
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*ADDR_W +: ADDR_W];
        chk($sformatf("b1_data[r%0d]", a), 64'(rd_data_b1[i*DATA_W +: DATA_W]), 64'(exp_data(a, 1)));
        chk($sformatf("b0_data[r%0d]", a), 64'(rd_data_b0[i*DATA_W +: DATA_W]), 64'(exp_data(a, 0)));
        chk($sformatf("b1_busy[r%0d]", a), 64'(rd_busy_b1[i]), 64'(exp_busy(a, 1)));
        chk($sformatf("b0_busy[r%0d]", a), 64'(rd_busy_b0[i]), 64'(exp_busy(a, 0)));
      end
    end
  endtask

  task automatic model_step();
    logic [ADDR_W-1:0] a;
    if (!Reset_n) begin
      for (int r = 0; r < NREG; r++) begin m_rf[r] = '0; m_busy[r] = 0; end
      m_sweep = 0;
      m_valid = 1;
    end else if (m_sweep) begin
      m_rf[m_cnt] = '0;
      m_busy[m_cnt] = 0;
      if (m_cnt == NREG - 1) m_sweep = 0; else m_cnt++;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        a = wr_addr[j*ADDR_W +: ADDR_W];
        if (wr_en[j] && a != 0) begin m_rf[a] = wr_data[j*DATA_W +: DATA_W]; m_busy[a] = 0; end
      end
      for (int j = 0; j < NWR; j++) begin
        a = rsv_addr[j*ADDR_W +: ADDR_W];
        if (rsv_en[j] && a != 0) m_busy[a] = 1;
      end
      if (clear_req) begin m_sweep = 1; m_cnt = 1; end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    if (m_valid) check_outputs();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; rsv_en = '0; clear_req = 0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  task automatic rd_all(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NRD; i++) rd_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input int port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en[port] = 1;
    wr_addr[port*ADDR_W +: ADDR_W] = a;
    wr_data[port*DATA_W +: DATA_W] = d;
  endtask

  task automatic rsv(input int port, input logic [ADDR_W-1:0] a);
    rsv_en[port] = 1;
    rsv_addr[port*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic read_sweep();
    idle_inputs();
    for (int a = 0; a < NREG; a += NRD) begin
      for (int i = 0; i < NRD; i++) rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a + i);
      tick();
    end
  endtask

  task automatic fill_all();
    idle_inputs();
    for (int a = 1; a < NREG; a += 2) begin
      wr(0, ADDR_W'(a), $urandom | 32'h1);
      if (a + 1 < NREG) wr(1, ADDR_W'(a + 1), $urandom | 32'h1);
      tick();
      idle_inputs();
    end
  endtask

  initial begin
    int n;
    Reset_n = 0;
    idle_inputs();
    rd_all(5);
    // Reset with writes active: none may land.
    wr(0, 5, 32'h1234_5678); wr(1, 6, 32'h9abc_def0);
    tick(); tick();
    Reset_n = 1;
    read_sweep();

    // Write priority and bypass on r5.
    idle_inputs(); rd_all(5);
    wr(0, 5, 32'h1111_1111); wr(1, 5, 32'hAAAA_AAAA);
    tick();
    idle_inputs();
    tick();
    chk("r5_after_write", 64'(rd_data_b0[DATA_W-1:0]), 64'h0000_0000_AAAA_AAAA);

    // Register zero.
    rd_all(0);
    wr(0, 0, 32'hDEAD_BEEF); rsv(1, 0);
    tick();
    idle_inputs();
    tick();

    // Scoreboard.
    rd_addr = {5'd9, 5'd7, 5'd9, 5'd7};
    rsv(0, 7); tick(); idle_inputs();
    tick();
    chk("r7_busy_after_rsv", 64'(rd_busy_b1[0]), 64'd1);
    wr(0, 7, 32'h42); rsv(1, 9); tick(); idle_inputs();
    tick();
    chk("r9_busy_after_rsv", 64'(rd_busy_b0[1]), 64'd1);
    wr(1, 7, 32'h43); rsv(0, 7); tick(); idle_inputs();
    tick();
    chk("r7_busy_rsv_beats_write", 64'(rd_busy_b0[0]), 64'd1);

    // Directed clear sweep with a dropped write mid-sweep.
    fill_all();
    rsv(0, 4); rsv(1, 17); tick(); idle_inputs();
    rsv(0, 31); rsv(1, 1); tick(); idle_inputs();
    rd_all(3);
    clear_req = 1; tick(); clear_req = 0;
    n = 0;
    while (clear_busy_b1 && n < 40) begin
      if (n == 5) wr(0, 3, 32'h3333_3333);
      tick();
      idle_inputs();
      n++;
    end
    chk("clear_len", 64'(n), 64'd31);
    read_sweep();

    // Reset in the middle of a sweep.
    fill_all();
    clear_req = 1; tick(); clear_req = 0;
    for (int k = 0; k < 10; k++) tick();
    Reset_n = 0; tick();
    Reset_n = 1;
    chk("clear_busy_after_reset", 64'(clear_busy_b1), 64'd0);
    rd_all(4);
    wr(0, 4, 32'h55); tick(); idle_inputs();
    tick();
    chk("r4_after_reset", 64'(rd_data_b0[DATA_W-1:0]), 64'h55);
    read_sweep();

    // Randomized traffic, focused on a few registers to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < NWR; j++) begin
        wr_en[j]  = $urandom_range(0, 1);
        rsv_en[j] = ($urandom_range(0, 3) == 0);
        wr_addr[j*ADDR_W +: ADDR_W]  = (c < 300) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
        rsv_addr[j*ADDR_W +: ADDR_W] = (c < 300) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
        wr_data[j*DATA_W +: DATA_W]  = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rd_addr[i*ADDR_W +: ADDR_W] = (c < 300) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      clear_req = ($urandom_range(0, 99) == 0);
      Reset_n   = ($urandom_range(0, 249) != 0);
      tick();
    end
    Reset_n = 1;
    idle_inputs();
    for (int k = 0; k < 40; k++) tick();
    read_sweep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS pipeline, the successor to the fixed two-read/two-write file. It has a configurable number of read and write ports, deterministic write-port priority, optional same-cycle write-to-read bypass, and a per-register scoreboard (busy bits) for the issue stage. A multi-cycle hardware clear sweep is included. The block sits between decode/issue (reads, reservations) and writeback (writes).

## Interface

Parameters:

- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREG = 2**ADDR_W registers
- NRD, 4, number of read ports
- NWR, 2, number of write ports (also the number of reserve ports)
- BYPASS, 1, 1 = same-cycle write data and busy-clear are visible on reads; 0 = registered state only

Ports:

- Clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Rd_addr  in  NRD*ADDR_W  read addresses; port i is slice [i*ADDR_W +: ADDR_W]
- Rd_data  out  NRD*DATA_W  read data, combinational
- Rd_busy  out  NRD  busy bit of each read address, combinational
- Wr_en  in  NWR  write enables
- Wr_addr  in  NWR*ADDR_W  write addresses
- Wr_data  in  NWR*DATA_W  write data
- Rsv_en  in  NWR  reserve enables (set busy on a destination at issue)
- Rsv_addr  in  NWR*ADDR_W  reserve addresses
- Clear_req  in  1  start a clear sweep (level sampled in IDLE)
- Clear_busy  out  1  high while the sweep runs

## Operation

- Register 0 always reads 0 and is never busy. Writes and reserves to address 0 are ignored.
- **Write:** on an edge with Wr_en[j] and Reset_n high, in IDLE, rf[Wr_addr[j]] <= Wr_data[j] and busy[Wr_addr[j]] <= 0.
  - If several ports target the same address, the highest-index port wins.
- **Reserve:** Rsv_en[j] sets busy[Rsv_addr[j]] <= 1.
  - Reserve beats a write-clear to the same address in the same cycle.
  - busy is a single bit: reserving an already-busy register keeps it at 1, with no count.
- **Read, BYPASS=1:**
  - If any enabled write port targets Rd_addr[i] (address ≠ 0), Rd_data[i] is the winning write's data.
  - Otherwise Rd_data[i] = rf[Rd_addr[i]].
  - Rd_busy[i] = 0 if a write targets that address this cycle and no reserve does; otherwise busy[Rd_addr[i]].
  - Same-cycle reserves never raise Rd_busy.
- **Read, BYPASS=0:** Rd_data[i] = rf[Rd_addr], Rd_busy[i] = busy[Rd_addr].
- **Clear FSM**, states IDLE and SWEEP, with a counter idx of ADDR_W bits:
  - IDLE, Clear_req=1 → SWEEP, idx <= 1.
  - SWEEP: each edge sets rf[idx] <= 0, busy[idx] <= 0, idx <= idx+1. When idx == NREG-1, go to IDLE after clearing it.
  - In SWEEP, writes and reserves are dropped, Clear_req is ignored, and bypass is disabled. Reads return the live, partially cleared array.
- **Reset** (Reset_n=0 at an edge): all rf <= 0, all busy <= 0, state IDLE, idx 0. Reset overrides every other input, including mid-sweep.

## Timing

Reset values:

- Rd_data: 0 for all ports
- Rd_busy: 0
- Clear_busy: 0

Latencies:

- Write to read: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Reserve to Rd_busy=1: 1 cycle.
- Clear: Clear_busy rises on the edge after Clear_req is seen in IDLE and stays high exactly NREG-1 cycles (31 cycles at default parameters).
  - The first write accepted after a sweep is on the edge where Clear_busy is already 0.
- Rd_data and Rd_busy have no clock delay: they are pure combinational functions of the addresses, current state and same-cycle writes.

## Test plan

1. **Reset:** hold Reset_n=0 for 2 cycles with writes active, then release.
   - All Rd_data = 0, Rd_busy = 0, Clear_busy = 0.
   - No write from the reset cycles lands.
2. **Write priority and bypass:** in the same cycle, port0 writes r5 = 0x1111_1111 and port1 writes r5 = 0xAAAA_AAAA; read r5 on all ports.
   - Same cycle: 0xAAAA_AAAA with BYPASS=1.
   - Next cycle: 0xAAAA_AAAA.
   - Repeat with BYPASS=0: old value 0, then 0xAAAA_AAAA.
3. **Register zero:** write 0xDEAD_BEEF and reserve r0.
   - Rd_data for r0 = 0 and Rd_busy = 0, both that cycle and later.
4. **Scoreboard:** reserve r7 → Rd_busy(r7) = 1 next cycle.
   - Write r7 = 0x42 with a reserve of r9 in the same cycle → Rd_busy(r7) = 0 that cycle (bypass) and after; r9 busy = 1 next cycle.
   - Reserve and write r7 in the same cycle → busy stays 1.
5. **Clear sweep:** fill r1..r31 with nonzero values and reserve several registers, then pulse Clear_req.
   - Clear_busy is high for exactly 31 cycles.
   - A write to r3 during the sweep is dropped.
   - Afterwards all registers read 0 and are not busy.
6. **Reset mid-sweep:** assert Reset_n=0 at sweep cycle 10.
   - Next cycle: Clear_busy = 0, all registers 0, IDLE.
   - A new write is accepted immediately after release.
